fuzz_vector_sequencer: RTL and testbench

//  Sequences a stored list of stimulus vectors into a fuzzed DUT (`top`) one vector per HOLD

---
 rtl/fuzz_seq_pkg.sv | 7 +
 rtl/fuzz_misr.sv | 43 ++++
 rtl/fuzz_vector_sequencer.sv | 149 ++++++++++++++
 tb/tb_fuzz_vector_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fuzz_seq_pkg.sv
// Shared types and constants for the fuzz vector sequencer.
package fuzz_seq_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [31:0] SIG_POLY = 32'h04C11DB7;
    localparam logic [31:0] SIG_SEED = '1;
endpackage

// File: rtl/fuzz_misr.sv
// MISR: folds the wide DUT output bus into SIG_W bits by XOR of SIG_W-wide
// chunks (last chunk zero-padded), then applies one Galois LFSR step.
module fuzz_misr
    import fuzz_seq_pkg::*;
#(
    parameter int Y_W   = 567,
    parameter int SIG_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_init,
    input  logic             i_en,
    input  logic [Y_W-1:0]   i_y,
    output logic [SIG_W-1:0] o_sig
);
    localparam int NCH = (Y_W + SIG_W - 1) / SIG_W;
    localparam int PW  = NCH * SIG_W;

    logic [PW-1:0]    w_pad;
    logic [SIG_W-1:0] w_fold;
    logic [SIG_W-1:0] w_next;
    logic [SIG_W-1:0] r_sig;

    // Fold the bus into one word and compute the next signature
    always_comb begin
        w_pad  = PW'(i_y);
        w_fold = '0;
        for (int c = 0; c < NCH; c++)
            w_fold = w_fold ^ w_pad[c*SIG_W +: SIG_W];
        w_next = {r_sig[SIG_W-2:0], 1'b0}
               ^ (r_sig[SIG_W-1] ? SIG_W'(SIG_POLY) : '0)
               ^ w_fold;
    end

    // Signature register: seeded on init, stepped on each sample
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    r_sig <= SIG_W'(SIG_SEED);
        else if (i_init) r_sig <= SIG_W'(SIG_SEED);
        else if (i_en)   r_sig <= w_next;
    end

    assign o_sig = r_sig;
endmodule

// File: rtl/fuzz_vector_sequencer.sv
// Plays stored stimulus vectors into a fuzzed DUT, one every HOLD clocks,
// and compresses each sampled output bus into a MISR signature.
// Optional: define FUZZ_SEQ_CMP_EN to add a golden-signature comparator
// (i_golden input, o_mismatch output).
module fuzz_vector_sequencer
    import fuzz_seq_pkg::*;
#(
    parameter int VEC_W = 53,
    parameter int Y_W   = 567,
    parameter int DEPTH = 32,
    parameter int HOLD  = 1,
    parameter int SIG_W = 32,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [CNT_W-2:0] i_wr_addr,
    input  logic [VEC_W-1:0] i_wr_data,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_num_vec,
    input  logic             i_abort,
`ifdef FUZZ_SEQ_CMP_EN
    input  logic [SIG_W-1:0] i_golden,
    output logic             o_mismatch,
`endif
    output logic [VEC_W-1:0] o_dut_in,
    input  logic [Y_W-1:0]   i_dut_y,
    output logic [CNT_W-1:0] o_vec_idx,
    output logic             o_cap_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic [SIG_W-1:0] o_signature
);
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    logic [VEC_W-1:0] r_mem [DEPTH];
    state_t           r_state, w_state_nxt;
    logic [VEC_W-1:0] r_dut_in;
    logic [CNT_W-1:0] r_vec_idx, r_num, w_nxt_idx, w_num_sat;
    logic [HW-1:0]    r_hold;
    logic             w_accept, w_hold_last, w_last, w_cap, w_busy, w_done;
    logic [VEC_W-1:0] w_mem0;

    assign w_accept    = (r_state == IDLE) && i_start;
    assign w_hold_last = (r_hold == HW'(HOLD - 1));
    assign w_nxt_idx   = r_vec_idx + CNT_W'(1);
    assign w_last      = (w_nxt_idx >= r_num);
    // Abort in the sampling cycle suppresses the capture
    assign w_cap       = (r_state == RUN) && w_hold_last && !i_abort;
    assign w_num_sat   = (i_num_vec > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : i_num_vec;
    // A write to entry 0 in the start cycle is forwarded to the first vector
    assign w_mem0      = (i_wr_en && i_wr_addr == '0) ? i_wr_data : r_mem[0];

    // Vector memory: writes only while idle, never cleared
    always_ff @(posedge i_clk) begin
        if (i_wr_en && !w_busy) r_mem[i_wr_addr] <= i_wr_data;
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: if (i_start) w_state_nxt = (i_num_vec != '0) ? RUN : FIN;
            RUN: begin
                w_busy = 1'b1;
                if (i_abort)                  w_state_nxt = IDLE;
                else if (w_hold_last && w_last) w_state_nxt = FIN;
            end
            FIN: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Vector stepping: hold counter, index and the vector driven to the DUT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dut_in  <= '0;
            r_vec_idx <= '0;
            r_hold    <= '0;
            r_num     <= '0;
        end else if (w_accept) begin
            r_num     <= w_num_sat;
            r_vec_idx <= '0;
            r_hold    <= '0;
            r_dut_in  <= (i_num_vec != '0) ? w_mem0 : '0;
        end else if (r_state == RUN) begin
            if (i_abort) begin
                r_dut_in <= '0;
            end else if (w_hold_last) begin
                r_hold <= '0;
                if (w_last) begin
                    r_dut_in <= '0;
                end else begin
                    r_dut_in  <= r_mem[w_nxt_idx[CNT_W-2:0]];
                    r_vec_idx <= w_nxt_idx;
                end
            end else begin
                r_hold <= r_hold + HW'(1);
            end
        end
    end

    fuzz_misr #(.Y_W(Y_W), .SIG_W(SIG_W)) u_misr (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_init (w_accept),
        .i_en   (w_cap),
        .i_y    (i_dut_y),
        .o_sig  (o_signature)
    );

`ifdef FUZZ_SEQ_CMP_EN
    logic [SIG_W-1:0] r_golden;
    logic             r_mismatch;

    // Golden latch and compare once the final signature has settled (FIN)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_golden   <= '0;
            r_mismatch <= 1'b0;
        end else if (w_accept) begin
            r_golden   <= i_golden;
            r_mismatch <= 1'b0;
        end else if (r_state == FIN) begin
            r_mismatch <= (o_signature != r_golden);
        end
    end

    assign o_mismatch = r_mismatch;
`endif

    assign o_dut_in    = r_dut_in;
    assign o_vec_idx   = r_vec_idx;
    assign o_cap_valid = w_cap;
    assign o_busy      = w_busy;
    assign o_done      = w_done;
endmodule

// File: tb/tb_fuzz_vector_sequencer.sv
// Directed bench for fuzz_vector_sequencer: one HOLD=1 and one HOLD=3 instance.
// Comparator checks are compiled in when FUZZ_SEQ_CMP_EN is defined.
module tb_fuzz_vector_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [52:0] wr_data = '0;
    logic        start1 = 1'b0, start3 = 1'b0;
    logic [5:0]  num_vec = '0;
    logic        abort = 1'b0;
    logic [566:0] noise = '0;

    logic [52:0]  din1, din3;
    logic [566:0] y1, y3;
    logic [5:0]   idx1, idx3;
    logic         cap1, cap3, busy1, busy3, done1, done3;
    logic [31:0]  sig1, sig3;
`ifdef FUZZ_SEQ_CMP_EN
    logic [31:0]  golden = '0;
    logic         mm1, mm3;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // DUT model: output bus is a fixed scramble of its input vector
    function automatic logic [566:0] mk_y(input logic [52:0] v);
        logic [566:0] y;
        y = 567'(v);
        y = y ^ (567'(v) << 200);
        y = y ^ (567'(~v) << 500);
        y = y ^ (567'(v) << 514);
        return y;
    endfunction

    // Reference signature step, bit by bit
    function automatic logic [31:0] step(input logic [31:0] s, input logic [566:0] y);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < 567; i++) f[i % 32] = f[i % 32] ^ y[i];
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
    endfunction

    assign y1 = mk_y(din1);
    assign y3 = mk_y(din3) ^ noise;

    fuzz_vector_sequencer #(.HOLD(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_start(start1), .i_num_vec(num_vec), .i_abort(abort),
`ifdef FUZZ_SEQ_CMP_EN
        .i_golden(golden), .o_mismatch(mm1),
`endif
        .o_dut_in(din1), .i_dut_y(y1), .o_vec_idx(idx1), .o_cap_valid(cap1),
        .o_busy(busy1), .o_done(done1), .o_signature(sig1)
    );

    fuzz_vector_sequencer #(.HOLD(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_start(start3), .i_num_vec(num_vec), .i_abort(abort),
`ifdef FUZZ_SEQ_CMP_EN
        .i_golden(golden), .o_mismatch(mm3),
`endif
        .o_dut_in(din3), .i_dut_y(y3), .o_vec_idx(idx3), .o_cap_valid(cap3),
        .o_busy(busy3), .o_done(done3), .o_signature(sig3)
    );

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    typedef struct {
        logic        abort;
        logic [52:0] din;
        logic [5:0]  idx;
        logic        cap;
        logic        busy;
        logic        done;
    } row_t;

    row_t        tbl [6];
    logic [52:0] mv [8];
    logic [31:0] e2, e5, e7;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        mv[0] = 53'h0;             mv[1] = 53'h1;
        mv[2] = 53'h1FFFFF;        mv[3] = 53'h1FFFFFFFFFFFFF;
        mv[4] = 53'h0A5A5A5A5A5A5; mv[5] = 53'h123456789ABCD;
        mv[6] = 53'h0F0F0F0F0F0F0; mv[7] = 53'h1555555555555;

        tbl[0] = '{1'b0, mv[0], 6'd0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b0, mv[1], 6'd1, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, mv[2], 6'd2, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, mv[3], 6'd3, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 53'h0,  6'd3, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 53'h0,  6'd3, 1'b0, 1'b0, 1'b0};

        e2 = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) e2 = step(e2, mk_y(mv[i]));
        e5 = step(step(32'hFFFFFFFF, mk_y(mv[0])), mk_y(mv[1]));
        e7 = step(32'hFFFFFFFF, mk_y(53'h0BEEF));

        // Reset state
        #12;
        chk("rst_din", din1, 0);
        chk("rst_idx", idx1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_cap", cap1, 0);
        chk("rst_sig", sig1, 32'hFFFFFFFF);
        chk("rst_sig3", sig3, 32'hFFFFFFFF);
        @(negedge clk); rst_n = 1'b1;

        // Load 8 vectors
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = mv[i];
        end
        @(negedge clk); wr_en = 1'b0;

        // Test 1: reset in the middle of an 8-vector run
        start1 = 1'b1; num_vec = 6'd8;
        @(negedge clk); start1 = 1'b0;
        begin
            int t = 0;
            while (idx1 !== 6'd3 && t < 20) begin @(negedge clk); t++; end
        end
        chk("t1_reach_idx3", idx1, 3);
        chk("t1_din_before_rst", din1, mv[3]);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_din", din1, 0);
        chk("t1_rst_idx", idx1, 0);
        chk("t1_rst_busy", busy1, 0);
        chk("t1_rst_sig", sig1, 32'hFFFFFFFF);
        @(negedge clk); rst_n = 1'b1;

        // Test 2: four vectors back to back, memory kept across reset
        @(negedge clk); start1 = 1'b1; num_vec = 6'd4;
        @(negedge clk); start1 = 1'b0;
        for (int r = 0; r < 6; r++) begin
            abort = tbl[r].abort;
            #1;
            chk($sformatf("t2_din[%0d]", r), din1, tbl[r].din);
            chk($sformatf("t2_idx[%0d]", r), idx1, tbl[r].idx);
            chk($sformatf("t2_cap[%0d]", r), cap1, tbl[r].cap);
            chk($sformatf("t2_busy[%0d]", r), busy1, tbl[r].busy);
            chk($sformatf("t2_done[%0d]", r), done1, tbl[r].done);
            @(negedge clk);
        end
        chk("t2_sig", sig1, e2);

        // Test 3: HOLD=3, N=2, output bus disturbed outside sample cycles
        start3 = 1'b1; num_vec = 6'd2;
        @(negedge clk); start3 = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            logic ecap;
            ecap = (c == 3 || c == 6);
            if (ecap) noise = '0;
            else begin
                for (int w = 0; w < 17; w++) noise[w*32 +: 32] = $urandom;
                noise[566:544] = 23'($urandom);
            end
            #1;
            chk($sformatf("t3_cap[%0d]", c), cap3, ecap);
            chk($sformatf("t3_idx[%0d]", c), idx3, (c <= 3) ? 0 : 1);
            chk($sformatf("t3_din[%0d]", c), din3, (c <= 3) ? mv[0] : (c <= 6) ? mv[1] : 53'h0);
            chk($sformatf("t3_done[%0d]", c), done3, c == 7);
            @(negedge clk);
        end
        noise = '0;
        chk("t3_sig", sig3, e5);

        // Test 4: start with zero vectors
        start1 = 1'b1; num_vec = 6'd0;
        @(negedge clk); start1 = 1'b0;
        #1;
        chk("t4_done", done1, 1);
        chk("t4_busy", busy1, 0);
        chk("t4_din", din1, 0);
        chk("t4_sig", sig1, 32'hFFFFFFFF);
        @(negedge clk);
        chk("t4_done_clr", done1, 0);

        // Test 5: abort at vec 2 of 5; writes/starts during the run ignored
        start1 = 1'b1; num_vec = 6'd5;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 53'h0DEAD;
        chk("t5_idx0", idx1, 0);
        chk("t5_busy", busy1, 1);
        @(negedge clk);
        wr_en = 1'b0;
        chk("t5_idx1", idx1, 1);
        chk("t5_din1", din1, mv[1]);
        @(negedge clk);
        start1 = 1'b0;
        chk("t5_idx2", idx1, 2);
        chk("t5_din2_nowrite", din1, mv[2]);
        abort = 1'b1;
        #1;
        chk("t5_cap_abort", cap1, 0);
        @(negedge clk);
        abort = 1'b0;
        chk("t5_din_off", din1, 0);
        chk("t5_busy_off", busy1, 0);
        chk("t5_no_done", done1, 0);
        chk("t5_sig", sig1, e5);
        @(negedge clk);
        chk("t5_no_done2", done1, 0);
        chk("t5_sig_hold", sig1, e5);

`ifdef FUZZ_SEQ_CMP_EN
        // Test 6: golden comparator
        for (int g = 0; g < 2; g++) begin
            golden = (g == 0) ? e2 : (e2 ^ 32'h1);
            start1 = 1'b1; num_vec = 6'd4;
            @(negedge clk); start1 = 1'b0;
            chk($sformatf("t6_clr[%0d]", g), mm1, 0);
            repeat (5) @(negedge clk);
            chk($sformatf("t6_sig[%0d]", g), sig1, e2);
            chk($sformatf("t6_mm[%0d]", g), mm1, g);
        end
`endif

        // Test 7: write to entry 0 in the start cycle is used by the run
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 53'h0BEEF;
        start1 = 1'b1; num_vec = 6'd1;
        @(negedge clk);
        wr_en = 1'b0; start1 = 1'b0;
        chk("t7_din_new", din1, 53'h0BEEF);
        @(negedge clk);
        chk("t7_done", done1, 1);
        chk("t7_sig", sig1, e7);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
